// File: rtl/skeleton_driver_if.sv
// Bundle of host-side and skeleton-side signals around skeleton_driver.
// Names carry the driver's own direction: i_ enters the driver, o_ leaves it.
interface skeleton_driver_if #(
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_HEAD = 32,
  parameter int FIFO_DEPTH    = 8
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic                      i_en;
  logic [BITWIDTH_SYS-1:0]   i_host_data_in;
  logic                      i_host_wr;
  logic                      i_host_start;
  logic                      i_host_rd;
  logic                      i_host_clr_err;
  logic [BITWIDTH_SYS-1:0]   o_host_data_out;
  logic                      o_tx_full;
  logic                      o_rx_empty;
  logic [AW:0]               o_rx_count;
  logic                      o_busy;
  logic                      o_done;
  logic                      o_error;
  logic [BITWIDTH_HEAD-7:0]  o_head_reg;
  logic                      o_skel_en;
  logic                      o_skel_start_flag;
  logic [BITWIDTH_SYS-1:0]   o_skel_data_in;
  logic [BITWIDTH_SYS-1:0]   i_skel_data_out;
  logic [BITWIDTH_HEAD-7:0]  i_skel_data_head;
  logic                      i_skel_data_valid;

  // The driver itself.
  modport slave (
    input  i_en, i_host_data_in, i_host_wr, i_host_start, i_host_rd, i_host_clr_err,
    input  i_skel_data_out, i_skel_data_head, i_skel_data_valid,
    output o_host_data_out, o_tx_full, o_rx_empty, o_rx_count, o_busy, o_done,
    output o_error, o_head_reg, o_skel_en, o_skel_start_flag, o_skel_data_in
  );

  // Host plus skeleton, i.e. everything around the driver.
  modport master (
    output i_en, i_host_data_in, i_host_wr, i_host_start, i_host_rd, i_host_clr_err,
    output i_skel_data_out, i_skel_data_head, i_skel_data_valid,
    input  o_host_data_out, o_tx_full, o_rx_empty, o_rx_count, o_busy, o_done,
    input  o_error, o_head_reg, o_skel_en, o_skel_start_flag, o_skel_data_in
  );
endinterface

// File: rtl/skeleton_driver.sv
// Host-side driver for an echo skeleton: TX FIFO feeds the skeleton, valid
// results land in an RX FIFO, header latched at transaction start.
module skeleton_driver #(
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_HEAD = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int TIMEOUT       = 255
) (
  input logic              i_clk_sys,
  input logic              i_nrst,
  skeleton_driver_if.slave io_bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = BITWIDTH_HEAD - 6;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   PTR_ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [TW-1:0] TIMER_ONE   = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SEND  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [TW-1:0]           r_timer, w_timer_nxt;
  logic                    r_start_req;
  logic [BITWIDTH_SYS-1:0] r_tx_mem [FIFO_DEPTH];
  logic [BITWIDTH_SYS-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW:0]             r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [AW:0]             w_tx_wr_nxt, w_tx_rd_nxt, w_rx_wr_nxt, w_rx_rd_nxt;
  logic                    w_tx_empty, w_tx_full, w_tx_last, w_rx_empty, w_rx_full;
  logic                    w_tx_push, w_capture, w_rx_pop;
  logic                    r_busy, r_done, r_error, r_start_flag, r_tx_full, r_rx_empty, r_skel_en;
  logic [AW:0]             r_rx_count;
  logic [HW-1:0]           r_head;

  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[AW] != r_tx_rd[AW]) && (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]);
  assign w_tx_last  = ((r_tx_wr - r_tx_rd) == PTR_ONE);
  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[AW] != r_rx_rd[AW]) && (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]);

  assign w_tx_push = io_bus.i_en && (r_state == ST_IDLE) && io_bus.i_host_wr && !w_tx_full;
  assign w_capture = io_bus.i_en && (r_state == ST_SEND) && io_bus.i_skel_data_valid && !w_rx_full;
  assign w_rx_pop  = io_bus.i_en && io_bus.i_host_rd && !w_rx_empty;

  // Next-state and timeout-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    if (!io_bus.i_en) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_timer_nxt = '0;
          if (r_start_req && !w_tx_empty) begin
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_START: begin
          w_timer_nxt = '0;
          w_state_nxt = ST_SEND;
        end
        ST_SEND: begin
          if (w_capture) begin
            w_timer_nxt = '0;
            if (w_tx_last) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = ST_SEND;
            end
          end else if (!io_bus.i_skel_data_valid) begin
            // A valid cycle blocked by a full RX neither captures nor ages the timer.
            w_timer_nxt = r_timer + TIMER_ONE;
            if ((r_timer + TIMER_ONE) == TIMEOUT_VAL) begin
              w_state_nxt = ST_ERR;
            end else begin
              w_state_nxt = ST_SEND;
            end
          end else begin
            w_state_nxt = ST_SEND;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_ERR: begin
          w_timer_nxt = '0;
          if (io_bus.i_host_clr_err) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  // Next FIFO pointers; TX is flushed on the way into ERR.
  always_comb begin
    w_tx_wr_nxt = r_tx_wr;
    w_tx_rd_nxt = r_tx_rd;
    w_rx_wr_nxt = r_rx_wr;
    w_rx_rd_nxt = r_rx_rd;
    if (!io_bus.i_en) begin
      w_tx_wr_nxt = '0;
      w_tx_rd_nxt = '0;
      w_rx_wr_nxt = '0;
      w_rx_rd_nxt = '0;
    end else begin
      if (w_state_nxt == ST_ERR) begin
        w_tx_wr_nxt = '0;
        w_tx_rd_nxt = '0;
      end else begin
        if (w_tx_push) begin
          w_tx_wr_nxt = r_tx_wr + PTR_ONE;
        end else begin
          w_tx_wr_nxt = r_tx_wr;
        end
        if (w_capture) begin
          w_tx_rd_nxt = r_tx_rd + PTR_ONE;
        end else begin
          w_tx_rd_nxt = r_tx_rd;
        end
      end
      if (w_capture) begin
        w_rx_wr_nxt = r_rx_wr + PTR_ONE;
      end else begin
        w_rx_wr_nxt = r_rx_wr;
      end
      if (w_rx_pop) begin
        w_rx_rd_nxt = r_rx_rd + PTR_ONE;
      end else begin
        w_rx_rd_nxt = r_rx_rd;
      end
    end
  end

  // FIFO storage, unreset; reads are gated by the empty flags instead.
  always_ff @(posedge i_clk_sys) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wr[AW-1:0]] <= io_bus.i_host_data_in;
    end
    if (w_capture) begin
      r_rx_mem[r_rx_wr[AW-1:0]] <= io_bus.i_skel_data_out;
    end
  end

  // State, pointers and registered outputs.
  always_ff @(posedge i_clk_sys or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_start_req  <= 1'b0;
      r_tx_wr      <= '0;
      r_tx_rd      <= '0;
      r_rx_wr      <= '0;
      r_rx_rd      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_start_flag <= 1'b0;
      r_tx_full    <= 1'b0;
      r_rx_empty   <= 1'b1;
      r_rx_count   <= '0;
      r_head       <= '0;
      r_skel_en    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_start_req  <= io_bus.i_en && io_bus.i_host_start && (r_state == ST_IDLE);
      r_tx_wr      <= w_tx_wr_nxt;
      r_tx_rd      <= w_tx_rd_nxt;
      r_rx_wr      <= w_rx_wr_nxt;
      r_rx_rd      <= w_rx_rd_nxt;
      r_busy       <= (w_state_nxt == ST_START) || (w_state_nxt == ST_SEND) || (w_state_nxt == ST_DONE);
      r_done       <= (w_state_nxt == ST_DONE);
      r_error      <= (w_state_nxt == ST_ERR);
      r_start_flag <= (w_state_nxt == ST_START);
      r_tx_full    <= w_tx_full;
      r_rx_empty   <= (w_rx_wr_nxt == w_rx_rd_nxt);
      r_rx_count   <= w_rx_wr_nxt - w_rx_rd_nxt;
      r_head       <= (io_bus.i_en && (r_state == ST_START)) ? io_bus.i_skel_data_head : r_head;
      r_skel_en    <= io_bus.i_en;
    end
  end

  assign io_bus.o_host_data_out   = w_rx_empty ? '0 : r_rx_mem[r_rx_rd[AW-1:0]];
  assign io_bus.o_skel_data_in    = w_tx_empty ? '0 : r_tx_mem[r_tx_rd[AW-1:0]];
  assign io_bus.o_tx_full         = r_tx_full;
  assign io_bus.o_rx_empty        = r_rx_empty;
  assign io_bus.o_rx_count        = r_rx_count;
  assign io_bus.o_busy            = r_busy;
  assign io_bus.o_done            = r_done;
  assign io_bus.o_error           = r_error;
  assign io_bus.o_head_reg        = r_head;
  assign io_bus.o_skel_en         = r_skel_en;
  assign io_bus.o_skel_start_flag = r_start_flag;
endmodule

// File: tb/tb_skeleton_driver.sv
// Self-checking bench for skeleton_driver with a zero-latency echo skeleton.
module tb_skeleton_driver;
  localparam int SYS = 16, HEAD = 32, DEPTH = 8, TMO = 255;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  skeleton_driver_if #(.BITWIDTH_SYS(SYS), .BITWIDTH_HEAD(HEAD), .FIFO_DEPTH(DEPTH)) bus ();

  skeleton_driver #(
    .BITWIDTH_SYS(SYS), .BITWIDTH_HEAD(HEAD), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) u_dut (
    .i_clk_sys(clk),
    .i_nrst   (nrst),
    .io_bus   (bus)
  );

  always #5 clk = ~clk;

  // Echo skeleton: result is the word currently presented.
  assign bus.i_skel_data_out = bus.o_skel_data_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [15:0] w[$]);
    foreach (w[i]) begin
      bus.i_host_data_in = w[i];
      bus.i_host_wr = 1'b1;
      tick();
    end
    bus.i_host_wr = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [15:0] exp[$]);
    chk({tag, "_rx_count"}, 32'(bus.o_rx_count), 32'(exp.size()));
    foreach (exp[i]) begin
      chk({tag, "_rx_data"}, 32'(bus.o_host_data_out), 32'(exp[i]));
      bus.i_host_rd = 1'b1;
      tick();
    end
    bus.i_host_rd = 1'b0;
    chk({tag, "_rx_empty"}, 32'(bus.o_rx_empty), 32'd1);
  endtask

  // Start a transaction of n words; predicts DONE/BUSY timing from valid cycles.
  task automatic run_txn(input string tag, input int n, input bit rnd_valid);
    int  nv, exp_done, done_c, fall_c, flag_c, flag_n;
    logic v;
    nv = 0; exp_done = -1; done_c = -1; fall_c = -1; flag_c = -1; flag_n = 0;
    bus.i_host_start = 1'b1;
    tick();
    bus.i_host_start = 1'b0;
    for (int c = 0; c < 700; c++) begin
      if (bus.o_skel_start_flag) begin
        flag_n++;
        if (flag_c < 0) flag_c = c;
      end
      if (bus.o_done && done_c < 0) done_c = c;
      if (c >= 1 && !bus.o_busy) begin
        fall_c = c;
        break;
      end
      v = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.i_skel_data_valid = v;
      if (c >= 2 && v && nv < n) begin
        nv++;
        if (nv == n) exp_done = c + 1;
      end
      tick();
    end
    bus.i_skel_data_valid = 1'b0;
    chk({tag, "_flag_cycle"}, 32'(flag_c), 32'd1);
    chk({tag, "_flag_len"}, 32'(flag_n), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_c), 32'(exp_done));
    chk({tag, "_busy_fall"}, 32'(fall_c), 32'(exp_done + 1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.o_done), 32'd0);
    chk({tag, "_error"}, 32'(bus.o_error), 32'd0);
    chk({tag, "_rx_empty"}, 32'(bus.o_rx_empty), 32'd1);
    chk({tag, "_rx_count"}, 32'(bus.o_rx_count), 32'd0);
    chk({tag, "_head"}, 32'(bus.o_head_reg), 32'd0);
    chk({tag, "_flag"}, 32'(bus.o_skel_start_flag), 32'd0);
    chk({tag, "_skel_in"}, 32'(bus.o_skel_data_in), 32'd0);
    chk({tag, "_host_out"}, 32'(bus.o_host_data_out), 32'd0);
    chk({tag, "_tx_full"}, 32'(bus.o_tx_full), 32'd0);
  endtask

  initial begin
    logic [15:0] q[$], pre[$], w3[$], got[$], exp[$];
    logic [25:0] hv;
    int n, dones;

    bus.i_en = 1'b1; bus.i_host_data_in = 16'h0000; bus.i_host_wr = 1'b0;
    bus.i_host_start = 1'b0; bus.i_host_rd = 1'b0; bus.i_host_clr_err = 1'b0;
    bus.i_skel_data_valid = 1'b0; bus.i_skel_data_head = 26'h0410210;
    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    nrst = 1'b1;
    tick();
    chk("skel_en", 32'(bus.o_skel_en), 32'd1);

    // Echo of three fixed words.
    q = '{16'h1234, 16'hABCD, 16'h00FF};
    push_words(q);
    run_txn("echo3", 3, 1'b0);
    chk("echo3_head", 32'(bus.o_head_reg), 32'h0410210);
    read_expect("echo3", q);

    // Randomized transactions with random valid gaps.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, DEPTH);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(16'($urandom_range(0, 16'hFFFF)));
      hv = 26'($urandom);
      bus.i_skel_data_head = hv;
      push_words(q);
      run_txn("rnd", n, 1'b1);
      chk("rnd_head", 32'(bus.o_head_reg), 32'(hv));
      read_expect("rnd", q);
    end

    // Overflow: ninth word dropped; underflow read ignored.
    q.delete();
    for (int i = 0; i < DEPTH + 1; i++) q.push_back(16'h0A00 + 16'(i));
    push_words(q);
    chk("ovf_tx_full", 32'(bus.o_tx_full), 32'd1);
    run_txn("ovf", DEPTH, 1'b0);
    void'(q.pop_back());
    read_expect("ovf", q);
    bus.i_host_rd = 1'b1;
    tick(); tick();
    bus.i_host_rd = 1'b0;
    chk("unf_rx_count", 32'(bus.o_rx_count), 32'd0);
    chk("unf_rx_empty", 32'(bus.o_rx_empty), 32'd1);

    // RX backpressure: 7 prefilled, 3-word transaction stalls after one capture.
    pre.delete();
    for (int i = 0; i < 7; i++) pre.push_back(16'($urandom_range(0, 16'hFFFF)));
    push_words(pre);
    run_txn("pre", 7, 1'b0);
    w3 = '{16'hB001, 16'hB002, 16'hB003};
    push_words(w3);
    bus.i_skel_data_valid = 1'b1;
    bus.i_host_start = 1'b1;
    tick();
    bus.i_host_start = 1'b0;
    repeat (6) tick();
    chk("bp_stall_count", 32'(bus.o_rx_count), 32'(DEPTH));
    chk("bp_stall_busy", 32'(bus.o_busy), 32'd1);
    got.delete();
    dones = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.o_done) dones++;
      if (!bus.o_busy && bus.o_rx_empty) break;
      if (!bus.o_rx_empty) begin
        got.push_back(bus.o_host_data_out);
        bus.i_host_rd = 1'b1;
      end else begin
        bus.i_host_rd = 1'b0;
      end
      tick();
    end
    bus.i_host_rd = 1'b0;
    bus.i_skel_data_valid = 1'b0;
    exp = {pre, w3};
    chk("bp_count", 32'(got.size()), 32'(exp.size()));
    chk("bp_dones", 32'(dones), 32'd1);
    foreach (exp[i]) chk("bp_data", (i < got.size()) ? 32'(got[i]) : 32'hDEAD0000, 32'(exp[i]));

    // Timeout: no valid for TIMEOUT SEND cycles.
    push_words('{16'hC001, 16'hC002});
    bus.i_host_start = 1'b1;
    tick();
    bus.i_host_start = 1'b0;
    repeat (TMO + 1) tick();
    chk("tmo_err_early", 32'(bus.o_error), 32'd0);
    chk("tmo_busy_early", 32'(bus.o_busy), 32'd1);
    tick();
    chk("tmo_err", 32'(bus.o_error), 32'd1);
    chk("tmo_busy", 32'(bus.o_busy), 32'd0);
    chk("tmo_tx_flushed", 32'(bus.o_skel_data_in), 32'd0);
    chk("tmo_no_done", 32'(bus.o_done), 32'd0);
    tick(); tick();
    chk("tmo_sticky", 32'(bus.o_error), 32'd1);
    bus.i_host_clr_err = 1'b1;
    tick();
    bus.i_host_clr_err = 1'b0;
    chk("tmo_clr", 32'(bus.o_error), 32'd0);
    bus.i_host_start = 1'b1;
    tick();
    bus.i_host_start = 1'b0;
    tick(); tick();
    chk("tmo_tx_empty_start", 32'(bus.o_busy), 32'd0);
    push_words('{16'h5A5A});
    run_txn("post_err", 1, 1'b0);
    read_expect("post_err", '{16'h5A5A});

    // Abort with EN low mid-SEND.
    hv = 26'h155AA33;
    bus.i_skel_data_head = hv;
    push_words('{16'hD001, 16'hD002, 16'hD003});
    dones = 0;
    bus.i_host_start = 1'b1;
    tick();
    bus.i_host_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus.o_done) dones++;
      bus.i_skel_data_valid = (c == 2);
      tick();
    end
    bus.i_skel_data_valid = 1'b0;
    chk("abort_pre_count", 32'(bus.o_rx_count), 32'd1);
    bus.i_en = 1'b0;
    tick();
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_rx_count", 32'(bus.o_rx_count), 32'd0);
    chk("abort_rx_empty", 32'(bus.o_rx_empty), 32'd1);
    chk("abort_skel_in", 32'(bus.o_skel_data_in), 32'd0);
    chk("abort_skel_en", 32'(bus.o_skel_en), 32'd0);
    if (bus.o_done) dones++;
    bus.i_en = 1'b1;
    bus.i_skel_data_head = 26'h0000001;
    tick();
    if (bus.o_done) dones++;
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_head_kept", 32'(bus.o_head_reg), 32'(hv));
    bus.i_host_start = 1'b1;
    tick();
    bus.i_host_start = 1'b0;
    tick(); tick();
    chk("abort_tx_empty", 32'(bus.o_busy), 32'd0);

    // Asynchronous reset pulsed mid-SEND, between clock edges.
    push_words('{16'hE001, 16'hE002, 16'hE003, 16'hE004});
    bus.i_host_start = 1'b1;
    tick();
    bus.i_host_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.i_skel_data_valid = (c == 2);
      tick();
    end
    bus.i_skel_data_valid = 1'b0;
    chk("arst_pre_count", 32'(bus.o_rx_count), 32'd1);
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk_reset_outputs("arst");
    @(negedge clk);
    nrst = 1'b1;
    tick();
    chk("arst_no_done", 32'(bus.o_done), 32'd0);
    chk("arst_busy", 32'(bus.o_busy), 32'd0);
    bus.i_skel_data_head = 26'h0410210;
    push_words('{16'h7777, 16'h8888});
    run_txn("recover", 2, 1'b1);
    read_expect("recover", '{16'h7777, 16'h8888});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
